// File: rtl/proc_mem_pkg.sv
// Shared types for the process memory: routing classes, FIFO entry layout and
// block-tracker states.
package proc_mem_pkg;

   localparam int unsigned PAWUSER_WIDTH = 4;

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      DIVERT = 2'd1,
      BLOCK  = 2'd2
   } route_t;

   localparam int unsigned DEF_ID_W   = 4;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_LEN_W  = 8;

   typedef struct packed {
      logic [DEF_ID_W-1:0]      id;
      logic [DEF_ADDR_W-1:0]    addr;
      logic [DEF_LEN_W-1:0]     len;
      logic [PAWUSER_WIDTH-1:0] user;
   } proc_entry_t;

   typedef enum logic {
      BLK_IDLE   = 1'b0,
      BLK_WAIT_B = 1'b1
   } blk_state_t;

endpackage

// File: rtl/proc_fifo.sv
// Circular show-ahead FIFO of entry_t words; pointers carry a wrap bit so full
// and empty are distinguishable without extra state.
module proc_fifo
   import proc_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter type         entry_t = proc_entry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  entry_t                   push_data,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output entry_t                   pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          push_fire;
   logic          pop_fire;

   // Flags come from registered pointers only, so a pop never frees a slot
   // for a push in the same cycle.
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                       (wr_ptr_q[PW] != rd_ptr_q[PW]);
   assign push_ready = ~full;
   assign pop_valid  = ~empty;
   assign push_fire  = push_valid & push_ready;
   assign pop_fire   = pop_valid & pop_ready;
   assign pop_data   = mem[rd_ptr_q[PW-1:0]];
   assign count      = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_fire) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_fire && !pop_fire) begin
         count_d = count_q + 1'b1;
      end else if (pop_fire && !push_fire) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem[wr_ptr_q[PW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/proc_mem.sv
// Process memory: buffers diverted AW requests for replay on the merge path and
// tracks the single outstanding BLOCK transaction until its B response.
module proc_mem
   import proc_mem_pkg::*;
#(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned ID_W          = 4,
   parameter int unsigned LEN_W         = 8,
   parameter int unsigned PAWUSER_WIDTH = proc_mem_pkg::PAWUSER_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [ID_W-1:0]          push_id,
   input  logic [ADDR_W-1:0]        push_addr,
   input  logic [LEN_W-1:0]         push_len,
   input  logic [PAWUSER_WIDTH-1:0] push_user,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output logic [ID_W-1:0]          pop_id,
   output logic [ADDR_W-1:0]        pop_addr,
   output logic [LEN_W-1:0]         pop_len,
   output logic [PAWUSER_WIDTH-1:0] pop_user,
   input  logic                     blk_start,
   input  logic [ID_W-1:0]          blk_id,
   input  logic                     m_bvalid,
   input  logic                     m_bready,
   input  logic [ID_W-1:0]          m_bid,
   output logic                     proc_full,
   output logic                     proc_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     block_fin,
   output logic                     blk_err
);

   typedef struct packed {
      logic [ID_W-1:0]          id;
      logic [ADDR_W-1:0]        addr;
      logic [LEN_W-1:0]         len;
      logic [PAWUSER_WIDTH-1:0] user;
   } entry_t;

   entry_t push_entry;
   entry_t pop_entry;

   assign push_entry = '{id: push_id, addr: push_addr, len: push_len, user: push_user};
   assign pop_id     = pop_entry.id;
   assign pop_addr   = pop_entry.addr;
   assign pop_len    = pop_entry.len;
   assign pop_user   = pop_entry.user;

   proc_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_entry),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_data   (pop_entry),
      .full       (proc_full),
      .empty      (proc_empty),
      .count      (count)
   );

   blk_state_t      state_q;
   logic [ID_W-1:0] blk_id_q;
   logic            block_fin_q;
   logic            blk_err_q;
   logic            b_hit;

   assign b_hit     = m_bvalid & m_bready & (m_bid == blk_id_q);
   assign block_fin = block_fin_q;
   assign blk_err   = blk_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BLK_IDLE;
         blk_id_q    <= '0;
         block_fin_q <= 1'b0;
         blk_err_q   <= 1'b0;
      end else begin
         block_fin_q <= 1'b0;
         unique case (state_q)
            BLK_IDLE: begin
               if (blk_start) begin
                  blk_id_q <= blk_id;
                  state_q  <= BLK_WAIT_B;
               end
            end
            BLK_WAIT_B: begin
               if (b_hit) begin
                  block_fin_q <= 1'b1;
                  // A new BLOCK arriving with the completion takes over the slot.
                  if (blk_start) begin
                     blk_id_q <= blk_id;
                  end else begin
                     state_q <= BLK_IDLE;
                  end
               end else if (blk_start) begin
                  blk_err_q <= 1'b1;
               end
            end
            default: state_q <= BLK_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_mem.sv
// Directed bench for proc_mem: FIFO fill/full/stream behaviour and BLOCK tracking.
module tb_proc_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid, push_ready;
   logic [3:0]  push_id;
   logic [31:0] push_addr;
   logic [7:0]  push_len;
   logic [3:0]  push_user;
   logic        pop_valid, pop_ready;
   logic [3:0]  pop_id;
   logic [31:0] pop_addr;
   logic [7:0]  pop_len;
   logic [3:0]  pop_user;
   logic        blk_start;
   logic [3:0]  blk_id;
   logic        m_bvalid, m_bready;
   logic [3:0]  m_bid;
   logic        proc_full, proc_empty;
   logic [3:0]  count;
   logic        block_fin, blk_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   proc_mem dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_id    (push_id),
      .push_addr  (push_addr),
      .push_len   (push_len),
      .push_user  (push_user),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_id     (pop_id),
      .pop_addr   (pop_addr),
      .pop_len    (pop_len),
      .pop_user   (pop_user),
      .blk_start  (blk_start),
      .blk_id     (blk_id),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .m_bid      (m_bid),
      .proc_full  (proc_full),
      .proc_empty (proc_empty),
      .count      (count),
      .block_fin  (block_fin),
      .blk_err    (blk_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic v, input logic [31:0] a);
      push_valid = v;
      push_addr  = a;
      push_id    = a[3:0];
      push_len   = a[11:4];
      push_user  = ~a[3:0];
   endtask

   task automatic b_beat(input logic [3:0] id);
      m_bvalid = 1'b1;
      m_bready = 1'b1;
      m_bid    = id;
      step();
      m_bvalid = 1'b0;
      m_bready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total++; if (proc_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", proc_empty); end
      total++; if (proc_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", proc_full); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b want=0", pop_valid); end
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%b want=1", push_ready); end
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL reset_fin got=%b want=0", block_fin); end
      total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", blk_err); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         set_push(1'b1, 32'h100 + i);
         step();
         total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
      end
      total++; if (proc_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", proc_full); end
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fill_push_ready got=%b want=0", push_ready); end
      total++; if (pop_addr !== 32'h100) begin bad++; $display("FAIL fill_head got=%h want=100", pop_addr); end
      total++; if (pop_id !== 4'h0 || pop_len !== 8'h10 || pop_user !== 4'hf) begin
         bad++; $display("FAIL fill_head_fields got=%h/%h/%h want=0/10/f", pop_id, pop_len, pop_user);
      end
      set_push(1'b1, 32'h1ff);
      step();
      set_push(1'b0, 32'h0);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ninth_push_count got=%0d want=8", count); end
      total++; if (pop_addr !== 32'h100) begin bad++; $display("FAIL ninth_push_head got=%h want=100", pop_addr); end
   endtask

   task automatic test_full_pop_push();
      set_push(1'b1, 32'h200);
      pop_ready = 1'b1;
      total++; if (pop_addr !== 32'h100) begin bad++; $display("FAIL fullpop_head got=%h want=100", pop_addr); end
      step();
      set_push(1'b0, 32'h0);
      pop_ready = 1'b0;
      total++; if (count !== 4'd7) begin bad++; $display("FAIL fullpop_count got=%0d want=7", count); end
      total++; if (proc_full !== 1'b0) begin bad++; $display("FAIL fullpop_full got=%b want=0", proc_full); end
      // Drain; 0x200 must never appear since the push was refused.
      for (int i = 1; i < 8; i++) begin
         total++; if (pop_addr !== 32'h100 + i) begin bad++; $display("FAIL drain[%0d] got=%h want=%h", i, pop_addr, 32'h100 + i); end
         pop_ready = 1'b1;
         step();
         pop_ready = 1'b0;
      end
      total++; if (proc_empty !== 1'b1 || pop_valid !== 1'b0) begin
         bad++; $display("FAIL drain_empty got=%b/%b want=1/0", proc_empty, pop_valid);
      end
   endtask

   task automatic test_stream();
      int errs = 0;
      for (int c = 0; c <= 20; c++) begin
         set_push(c < 20, 32'h300 + c);
         pop_ready = (c > 0);
         if (c > 0 && (pop_valid !== 1'b1 || pop_addr !== 32'h300 + c - 1)) begin
            errs++; $display("FAIL stream_order[%0d] got=%h want=%h", c, pop_addr, 32'h300 + c - 1);
         end
         step();
         if (c < 20 && count !== 4'd1) begin
            errs++; $display("FAIL stream_count[%0d] got=%0d want=1", c, count);
         end
      end
      set_push(1'b0, 32'h0);
      pop_ready = 1'b0;
      total++; if (errs != 0) bad++;
      total++; if (proc_empty !== 1'b1 || count !== 4'd0) begin
         bad++; $display("FAIL stream_end got=%b/%0d want=1/0", proc_empty, count);
      end
   endtask

   task automatic test_block();
      blk_id = 4'd3; blk_start = 1'b1;
      step();
      blk_start = 1'b0;
      b_beat(4'd5);
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL blk_other_id got=%b want=0", block_fin); end
      b_beat(4'd3);
      total++; if (block_fin !== 1'b1) begin bad++; $display("FAIL blk_fin got=%b want=1", block_fin); end
      step();
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL blk_fin_width got=%b want=0", block_fin); end
      b_beat(4'd3);
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL blk_idle_no_fin got=%b want=0", block_fin); end
      total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL blk_no_err got=%b want=0", blk_err); end
   endtask

   task automatic test_block_err();
      blk_id = 4'd3; blk_start = 1'b1;
      step();
      blk_id = 4'd6;
      step();
      blk_start = 1'b0;
      total++; if (blk_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", blk_err); end
      b_beat(4'd6);
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL err_id_kept got=%b want=0", block_fin); end
      blk_id = 4'd7; blk_start = 1'b1;
      b_beat(4'd3);
      blk_start = 1'b0;
      total++; if (block_fin !== 1'b1) begin bad++; $display("FAIL coinc_fin got=%b want=1", block_fin); end
      b_beat(4'd3);
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL coinc_old_id got=%b want=0", block_fin); end
      b_beat(4'd7);
      total++; if (block_fin !== 1'b1) begin bad++; $display("FAIL coinc_new_id got=%b want=1", block_fin); end
      total++; if (blk_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", blk_err); end
   endtask

   task automatic test_reset_mid();
      blk_id = 4'd3; blk_start = 1'b1;
      step();
      blk_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'h400 + i);
         step();
      end
      set_push(1'b0, 32'h0);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL mid_pre_count got=%0d want=4", count); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (proc_empty !== 1'b1 || pop_valid !== 1'b0) begin
         bad++; $display("FAIL mid_empty got=%b/%b want=1/0", proc_empty, pop_valid);
      end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
      total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", blk_err); end
      b_beat(4'd3);
      total++; if (block_fin !== 1'b0) begin bad++; $display("FAIL mid_no_fin got=%b want=0", block_fin); end
      blk_id = 4'd5; blk_start = 1'b1;
      step();
      blk_start = 1'b0;
      total++; if (blk_err !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", blk_err); end
   endtask

   initial begin
      rst = 1'b1;
      set_push(1'b0, 32'h0);
      pop_ready = 1'b0;
      blk_start = 1'b0;
      blk_id    = 4'd0;
      m_bvalid  = 1'b0;
      m_bready  = 1'b0;
      m_bid     = 4'd0;
      test_reset();
      test_fill();
      test_full_pop_push();
      test_stream();
      test_block();
      test_block_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
